// File: rtl/button_cursor_pkg.sv
// -----------------------------------------------------------------------------
// button_cursor_pkg
// Definitions shared by the button/cursor front end and the VGA renderer:
//   dir_e      2-bit move direction encoding (U=0, D=1, L=2, R=3)
//   GRID_DIM   blocks per grid side (4x4 grid)
//   COORD_W    width of a row/column coordinate
//   step_coord one-step move of a coordinate, wrapping or saturating
// -----------------------------------------------------------------------------
package button_cursor_pkg;

  localparam int GRID_DIM = 4;
  localparam int COORD_W  = 2;

  typedef enum logic [1:0] {
    DIR_U = 2'd0,
    DIR_D = 2'd1,
    DIR_L = 2'd2,
    DIR_R = 2'd3
  } dir_e;

  // Move a coordinate by one. With GRID_DIM == 4 the 2-bit add/subtract
  // already wraps 3<->0; saturation pins the value at the grid edge.
  function automatic logic [COORD_W-1:0] step_coord(
    input logic [COORD_W-1:0] v,
    input logic               inc,
    input logic               wrap
  );
    logic [COORD_W-1:0] r;
    if (inc) begin
      r = (!wrap && v == COORD_W'(GRID_DIM - 1)) ? v : v + COORD_W'(1);
    end else begin
      r = (!wrap && v == '0) ? v : v - COORD_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/button_cursor_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// One raw pad button -> one-cycle move events.
//   2-FF synchronizer, then a debounce counter that flips the stable state only
//   after DEBOUNCE_CYCLES consecutive cycles of disagreement. A press (stable
//   0->1) emits one event; while held, events repeat after REPEAT_DELAY cycles
//   and then every REPEAT_PERIOD cycles. Release emits nothing.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous, active-high reset
//   raw    in  asynchronous pad input
//   evt    out registered one-cycle event strobe
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 15_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic evt
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  // Counters compare against "last count" values so the flip / repeat fires on
  // the N-th qualifying cycle.
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic             REPEAT_EN   = (REPEAT_DELAY != 0);

  logic             sync_a;
  logic             sync_b;
  logic             stable;
  logic             repeating;   // first auto-repeat already issued in this hold
  logic [DB_W-1:0]  db_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic             mismatch;
  logic             flip;
  logic [RPT_W-1:0] rpt_last;

  assign mismatch = sync_b ^ stable;
  assign flip     = mismatch && (db_cnt == DB_LAST);
  assign rpt_last = repeating ? PERIOD_LAST : DELAY_LAST;

  // NOTE: every register below uses non-blocking assignment so all of them
  // sample pre-edge values; blocking here would collapse the synchronizer.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      stable    <= 1'b0;
      repeating <= 1'b0;
      db_cnt    <= '0;
      rpt_cnt   <= '0;
      evt       <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      evt    <= 1'b0;

      // Any cycle of agreement restarts the debounce window.
      db_cnt <= (mismatch && !flip) ? db_cnt + DB_W'(1) : '0;

      if (flip) begin
        stable    <= ~stable;
        rpt_cnt   <= '0;
        repeating <= 1'b0;
        evt       <= ~stable;      // press only; release is silent
      end else if (stable && REPEAT_EN) begin
        // Repeat keeps running during a release that is still being debounced.
        if (rpt_cnt == rpt_last) begin
          evt       <= 1'b1;
          rpt_cnt   <= '0;
          repeating <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/button_cursor.sv
// -----------------------------------------------------------------------------
// button_cursor
// Debounced, auto-repeating 4-button cursor over the 4x4 block grid.
// Each pad feeds a button_debouncer; a fixed-priority arbiter (U > D > L > R)
// picks at most one event per cycle, which moves the registered cursor unless
// lock is high. The selected block's pixel origin is derived combinationally.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   BTNU/BTND/BTNL/BTNR     raw asynchronous pad buttons
//   lock                    1 = drop move events (debounce/repeat keep running)
//   block_x [9:0]           ORIGIN_X + cursor_col*PITCH
//   block_y [8:0]           ORIGIN_Y + cursor_row*PITCH
//   cursor_row/col [1:0]    selected row / column
//   cursor_idx [3:0]        row*4 + col
//   move_pulse              one-cycle strobe per accepted move (also at a
//                           saturated edge)
//   move_dir [1:0]          direction of the last move_pulse
// -----------------------------------------------------------------------------
module button_cursor
  import button_cursor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 15_000_000,
  parameter int ORIGIN_X        = 160,
  parameter int ORIGIN_Y        = 80,
  parameter int PITCH           = 80,
  parameter int WRAP            = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         BTNU,
  input  logic         BTND,
  input  logic         BTNL,
  input  logic         BTNR,
  input  logic         lock,
  output logic [9:0]   block_x,
  output logic [8:0]   block_y,
  output logic [1:0]   cursor_row,
  output logic [1:0]   cursor_col,
  output logic [3:0]   cursor_idx,
  output logic         move_pulse,
  output logic [1:0]   move_dir
);

  localparam logic WRAP_EN = (WRAP != 0);

  // Parameter sanity, reported at elaboration.
  if (ORIGIN_X + (GRID_DIM - 1) * PITCH >= 640) begin : g_bad_x
    $error("button_cursor: ORIGIN_X/PITCH place block_x off the 640-pixel line");
  end
  if (ORIGIN_Y + (GRID_DIM - 1) * PITCH >= 480) begin : g_bad_y
    $error("button_cursor: ORIGIN_Y/PITCH place block_y off the 480-line frame");
  end
  if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1) begin : g_bad_timing
    $error("button_cursor: DEBOUNCE_CYCLES and REPEAT_PERIOD must be >= 1");
  end

  // Bit position equals the dir_e encoding of each button.
  logic [3:0] raw;
  logic [3:0] evt;
  assign raw = {BTNR, BTNL, BTND, BTNU};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_debouncer (
      .clock (clock),
      .reset (reset),
      .raw   (raw[i]),
      .evt   (evt[i])
    );
  end

  // Fixed-priority arbiter: losers in the same cycle are simply dropped.
  logic win_valid;
  dir_e win_dir;

  // NOTE: both outputs get a default before the if-chain, so no path leaves
  // them unassigned and no latch is inferred.
  always_comb begin
    win_valid = |evt;
    win_dir   = DIR_U;
    if      (evt[DIR_U]) win_dir = DIR_U;
    else if (evt[DIR_D]) win_dir = DIR_D;
    else if (evt[DIR_L]) win_dir = DIR_L;
    else if (evt[DIR_R]) win_dir = DIR_R;
  end

  dir_e dir_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cursor_row <= '0;
      cursor_col <= '0;
      move_pulse <= 1'b0;
      dir_q      <= DIR_U;
    end else begin
      move_pulse <= 1'b0;
      if (win_valid && !lock) begin
        move_pulse <= 1'b1;
        dir_q      <= win_dir;
        case (win_dir)
          DIR_U: cursor_row <= step_coord(cursor_row, 1'b0, WRAP_EN);
          DIR_D: cursor_row <= step_coord(cursor_row, 1'b1, WRAP_EN);
          DIR_L: cursor_col <= step_coord(cursor_col, 1'b0, WRAP_EN);
          DIR_R: cursor_col <= step_coord(cursor_col, 1'b1, WRAP_EN);
          default: ;
        endcase
      end
    end
  end

  assign move_dir   = dir_q;
  assign cursor_idx = {cursor_row, cursor_col};

  // Pixel origin follows the registered cursor with no extra stage, so it
  // updates in the same cycle as move_pulse.
  assign block_x = 10'(ORIGIN_X) + 10'(PITCH) * {8'd0, cursor_col};
  assign block_y = 9'(ORIGIN_Y) + 9'(PITCH) * {7'd0, cursor_row};

endmodule

// File: tb/tb_button_cursor.sv
// -----------------------------------------------------------------------------
// tb_button_cursor
// Self-checking bench for button_cursor with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. A second instance built with WRAP=0 covers saturation.
// Directed presses come from a table; multi-cycle corners are hand-written;
// a final random phase is compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_button_cursor;
  import button_cursor_pkg::*;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       btnu, btnd, btnl, btnr, lock;
  logic [9:0] block_x;
  logic [8:0] block_y;
  logic [1:0] cursor_row, cursor_col, move_dir;
  logic [3:0] cursor_idx;
  logic       move_pulse;

  logic       s_btnu, s_btnd, s_btnl, s_btnr, s_lock;
  logic [9:0] s_block_x;
  logic [8:0] s_block_y;
  logic [1:0] s_row, s_col, s_dir;
  logic [3:0] s_idx;
  logic       s_move_pulse;

  always #5 clock = ~clock;

  button_cursor #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .ORIGIN_X(160), .ORIGIN_Y(80), .PITCH(80), .WRAP(1)
  ) dut (
    .clock(clock), .reset(reset),
    .BTNU(btnu), .BTND(btnd), .BTNL(btnl), .BTNR(btnr), .lock(lock),
    .block_x(block_x), .block_y(block_y),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_idx(cursor_idx),
    .move_pulse(move_pulse), .move_dir(move_dir)
  );

  button_cursor #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .ORIGIN_X(160), .ORIGIN_Y(80), .PITCH(80), .WRAP(0)
  ) dut_sat (
    .clock(clock), .reset(reset),
    .BTNU(s_btnu), .BTND(s_btnd), .BTNL(s_btnl), .BTNR(s_btnr), .lock(s_lock),
    .block_x(s_block_x), .block_y(s_block_y),
    .cursor_row(s_row), .cursor_col(s_col), .cursor_idx(s_idx),
    .move_pulse(s_move_pulse), .move_dir(s_dir)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pulses   = 0;
  int s_pulses = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (move_pulse)   pulses++;
      if (s_move_pulse) s_pulses++;
    end
  endtask

  // mask bit order follows dir_e: bit0=U bit1=D bit2=L bit3=R
  task automatic set_btns(input logic [3:0] m);
    btnu = m[0];
    btnd = m[1];
    btnl = m[2];
    btnr = m[3];
  endtask

  task automatic check_pos(input string tag, input int row, input int col);
    check({tag, "_row"},   int'(cursor_row), row);
    check({tag, "_col"},   int'(cursor_col), col);
    check({tag, "_bx"},    int'(block_x),    160 + 80 * col);
    check({tag, "_by"},    int'(block_y),    80 + 80 * row);
    check({tag, "_idx"},   int'(cursor_idx), row * 4 + col);
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: synced input is the raw level two edges back; the stable
  // level changes after DB consecutive disagreeing cycles; a press event fires
  // on that edge, repeats at hold times RD, RD+RP, RD+2RP, ...; the cursor acts
  // on the previous edge's events with U > D > L > R priority.
  // ---------------------------------------------------------------------------
  int m_h1[4], m_h2[4], m_stable[4], m_run[4], m_hold[4], m_evt[4];
  int m_row, m_col, m_dir, m_pulse;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_h1[b] = 0; m_h2[b] = 0; m_stable[b] = 0;
      m_run[b] = 0; m_hold[b] = 0; m_evt[b] = 0;
    end
    m_row = 0; m_col = 0; m_dir = 0; m_pulse = 0;
  endtask

  task automatic model_edge(input logic [3:0] raw, input logic lk);
    int w;
    int synced;
    int ev;
    bit flipped;
    w = -1;
    for (int d = 3; d >= 0; d--) if (m_evt[d] != 0) w = d;
    m_pulse = 0;
    if (w >= 0 && !lk) begin
      m_pulse = 1;
      m_dir   = w;
      case (w)
        0: m_row = (m_row + 3) % 4;
        1: m_row = (m_row + 1) % 4;
        2: m_col = (m_col + 3) % 4;
        default: m_col = (m_col + 1) % 4;
      endcase
    end
    for (int b = 0; b < 4; b++) begin
      synced  = m_h2[b];
      m_h2[b] = m_h1[b];
      m_h1[b] = int'(raw[b]);
      ev      = 0;
      flipped = 0;
      if (synced != m_stable[b]) m_run[b]++;
      else                       m_run[b] = 0;
      if (m_run[b] == DB) begin
        m_stable[b] = synced;
        m_run[b]    = 0;
        m_hold[b]   = 0;
        flipped     = 1;
        ev          = synced;
      end
      if (!flipped && m_stable[b] == 1) begin
        m_hold[b]++;
        if (m_hold[b] == RD || (m_hold[b] > RD && (m_hold[b] - RD) % RP == 0)) ev = 1;
      end
      m_evt[b] = ev;
    end
  endtask

  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] btns;
    logic       lk;
    int         exp_pulses;
    int         exp_row;
    int         exp_col;
    int         exp_dir;
  } vec_t;

  vec_t vecs[13];
  int   first_pulse;
  int   by_first;
  int   pt[$];
  int   pr[$];
  logic [3:0] rnd_btn;

  initial begin
    // Each entry: press for 12 cycles, release, settle 14 cycles.
    // Starting point: row 0, col 1, dir R (left by the steady-press test).
    vecs[0]  = '{4'b1000, 1'b0, 1, 0, 2, int'(DIR_R)};
    vecs[1]  = '{4'b0010, 1'b0, 1, 1, 2, int'(DIR_D)};
    vecs[2]  = '{4'b0100, 1'b0, 1, 1, 1, int'(DIR_L)};
    vecs[3]  = '{4'b0001, 1'b0, 1, 0, 1, int'(DIR_U)};
    vecs[4]  = '{4'b0001, 1'b0, 1, 3, 1, int'(DIR_U)};  // wrap 0 -> 3
    vecs[5]  = '{4'b0010, 1'b0, 1, 0, 1, int'(DIR_D)};  // wrap 3 -> 0
    vecs[6]  = '{4'b1000, 1'b0, 1, 0, 2, int'(DIR_R)};
    vecs[7]  = '{4'b1000, 1'b0, 1, 0, 3, int'(DIR_R)};
    vecs[8]  = '{4'b1000, 1'b0, 1, 0, 0, int'(DIR_R)};  // wrap 3 -> 0
    vecs[9]  = '{4'b0100, 1'b0, 1, 0, 3, int'(DIR_L)};  // wrap 0 -> 3
    vecs[10] = '{4'b0110, 1'b0, 1, 1, 3, int'(DIR_D)};  // L+D: D wins
    vecs[11] = '{4'b1111, 1'b0, 1, 0, 3, int'(DIR_U)};  // all: U wins
    vecs[12] = '{4'b0010, 1'b1, 0, 0, 3, int'(DIR_U)};  // locked: dropped

    reset = 1'b1; lock = 1'b0; set_btns(4'b0000);
    s_btnu = 1'b0; s_btnd = 1'b0; s_btnl = 1'b0; s_btnr = 1'b0; s_lock = 1'b0;
    step(3);
    reset = 1'b0;

    // Reset state
    check_pos("reset", 0, 0);
    check("reset_pulse", int'(move_pulse), 0);
    check("reset_dir",   int'(move_dir),   0);
    pulses = 0;
    step(20);
    check("idle_no_pulse", pulses, 0);

    // Glitches shorter than the debounce window are ignored
    btnr = 1'b1; step(1); btnr = 1'b0; step(15);
    btnr = 1'b1; step(3); btnr = 1'b0; step(15);
    check("glitch_no_pulse", pulses, 0);

    // Steady press: pulse exactly 7 edges after the pad rises
    pulses = 0;
    btnr = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step(1);
      if (c == 6) check("press_not_early", int'(move_pulse), 0);
    end
    check("press_pulse", int'(move_pulse), 1);
    check("press_dir",   int'(move_dir),   int'(DIR_R));
    check_pos("press", 0, 1);
    step(5);
    btnr = 1'b0;
    step(14);
    check("press_single", pulses, 1);

    // Table of single presses
    for (int i = 0; i < 13; i++) begin
      pulses = 0;
      lock = vecs[i].lk;
      set_btns(vecs[i].btns);
      step(12);
      set_btns(4'b0000);
      step(14);
      lock = 1'b0;
      check($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
      check($sformatf("vec%0d_dir", i), int'(move_dir), vecs[i].exp_dir);
      check_pos($sformatf("vec%0d", i), vecs[i].exp_row, vecs[i].exp_col);
    end

    // BTNU held from row 0; released after 59 edges so the debounced release
    // lands before the repeat that would be due at hold time 60.
    btnu = 1'b1;
    by_first = -1;
    for (int c = 1; c <= 100; c++) begin
      step(1);
      if (move_pulse) begin
        pt.push_back(c);
        pr.push_back(int'(cursor_row));
        if (by_first < 0) by_first = int'(block_y);
      end
      if (c == 59) btnu = 1'b0;
    end
    check("hold_count",  pt.size(), 6);
    check("hold_t0",     q_at(pt, 0), 7);
    check("hold_t1",     q_at(pt, 1), 27);
    check("hold_t2",     q_at(pt, 2), 35);
    check("hold_t5",     q_at(pt, 5), 59);
    check("hold_r0",     q_at(pr, 0), 3);
    check("hold_r1",     q_at(pr, 1), 2);
    check("hold_r2",     q_at(pr, 2), 1);
    check("hold_r3",     q_at(pr, 3), 0);
    check("hold_by0",    by_first, 320);
    check("hold_dir",    int'(move_dir), int'(DIR_U));
    check_pos("hold_end", 2, 3);

    // lock during press, then unlock while held: next repeat moves
    pulses = 0;
    lock = 1'b1; btnd = 1'b1;
    step(10);
    check("lock_no_pulse", pulses, 0);
    check("lock_row",      int'(cursor_row), 2);
    lock = 1'b0;
    step(17);
    btnd = 1'b0;
    step(15);
    check("unlock_pulses", pulses, 1);
    check("unlock_dir",    int'(move_dir), int'(DIR_D));
    check_pos("unlock", 3, 3);

    // Reset pulsed mid-hold: held button counts as a fresh press
    btnr = 1'b1;
    step(10);
    reset = 1'b1;
    step(2);
    check_pos("midrst", 0, 0);
    check("midrst_pulse", int'(move_pulse), 0);
    check("midrst_dir",   int'(move_dir),   0);
    reset = 1'b0;
    pulses = 0;
    first_pulse = -1;
    for (int c = 1; c <= 15; c++) begin
      step(1);
      if (move_pulse && first_pulse < 0) first_pulse = c;
    end
    check("midrst_latency", first_pulse, DB + 3);
    check("midrst_pulses",  pulses, 1);
    check_pos("midrst_after", 0, 1);
    btnr = 1'b0;
    step(15);

    // WRAP=0 instance: left at column 0 saturates but still pulses
    s_pulses = 0;
    for (int k = 0; k < 5; k++) begin
      s_btnl = 1'b1; step(12);
      s_btnl = 1'b0; step(14);
    end
    check("sat_pulses", s_pulses, 5);
    check("sat_col",    int'(s_col), 0);
    check("sat_bx",     int'(s_block_x), 160);
    check("sat_dir",    int'(s_dir), int'(DIR_L));

    // Random phase against the behavioural model
    reset = 1'b1; set_btns(4'b0000); lock = 1'b0;
    step(2);
    reset = 1'b0;
    model_reset();
    rnd_btn = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 29) == 0) rnd_btn[b] = ~rnd_btn[b];
      if ($urandom_range(0, 59) == 0) lock = ~lock;
      set_btns(rnd_btn);
      @(posedge clock);
      model_edge(rnd_btn, lock);
      #1;
      check("rand_pulse", int'(move_pulse), m_pulse);
      check("rand_dir",   int'(move_dir),   m_dir);
      check("rand_row",   int'(cursor_row), m_row);
      check("rand_col",   int'(cursor_col), m_col);
      check("rand_bx",    int'(block_x),    160 + 80 * m_col);
      check("rand_idx",   int'(cursor_idx), m_row * 4 + m_col);
    end
    set_btns(4'b0000);
    lock = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
